fold16_sig_acc: RTL and testbench

FOLD16_SIG_ACC -- requirements
Module: fold16_sig_acc

---
 rtl/fold16_sig_acc.sv | 100 ++++++++++
 tb/tb_fold16_sig_acc.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fold16_sig_acc.sv
// Folded-beat signature accumulator: rotate-left-1 / XOR fold of N_BEATS beats
// (aa XOR byte-swapped bb), then a held result with an exp_sig compare flag.
module fold16_sig_acc #(
  parameter int N_BEATS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] aa,
  input  logic [15:0] bb,
  input  logic [15:0] exp_sig,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] sig,
  output logic        match,
  output logic [1:0]  o_dbg_state
);

  localparam int CNT_W = $clog2(N_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_sig;
  logic             r_match;

  logic [15:0]      w_word;
  logic [15:0]      w_sig_next;
  logic             w_accept;
  logic             w_last;

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
  // the result transfers on a rising edge where out_valid && out_ready.
  // Neither valid may depend on its ready; both readies/valids come from state only.
  assign w_word     = aa ^ {bb[7:0], bb[15:8]};
  assign w_sig_next = {r_sig[14:0], r_sig[15]} ^ w_word;
  assign w_accept   = (r_state == S_ACC) && in_valid;
  assign w_last     = (r_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sig   <= 16'h0000;
      r_match <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sig   <= 16'h0000;
            r_cnt   <= '0;
            r_match <= 1'b0;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          if (w_accept) begin
            r_sig <= w_sig_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_match <= (w_sig_next == exp_sig);
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // A start coinciding with the result handshake skips IDLE entirely.
          if (out_ready) begin
            if (start) begin
              r_sig   <= 16'h0000;
              r_cnt   <= '0;
              r_match <= 1'b0;
              r_state <= S_ACC;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = (r_state == S_ACC);
  assign out_valid   = (r_state == S_DONE);
  assign sig         = r_sig;
  assign match       = r_match;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fold16_sig_acc.sv
// Directed bench for fold16_sig_acc: three instances (N_BEATS = 1, 2, 8) share
// inputs; each scenario resets them and checks only the instance it targets.
module tb_fold16_sig_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] aa = 16'h0000;
  logic [15:0] bb = 16'h0000;
  logic [15:0] exp_sig = 16'h0000;

  logic        in_ready1, out_valid1, match1;
  logic        in_ready2, out_valid2, match2;
  logic        in_ready8, out_valid8, match8;
  logic [15:0] sig1, sig2, sig8;
  logic [1:0]  dbg1, dbg2, dbg8;

  int n_cmp = 0;
  int n_fail = 0;

  fold16_sig_acc #(.N_BEATS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready1),
    .aa(aa), .bb(bb), .exp_sig(exp_sig), .out_valid(out_valid1), .out_ready(out_ready),
    .sig(sig1), .match(match1), .o_dbg_state(dbg1)
  );

  fold16_sig_acc #(.N_BEATS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
    .aa(aa), .bb(bb), .exp_sig(exp_sig), .out_valid(out_valid2), .out_ready(out_ready),
    .sig(sig2), .match(match2), .o_dbg_state(dbg2)
  );

  fold16_sig_acc #(.N_BEATS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready8),
    .aa(aa), .bb(bb), .exp_sig(exp_sig), .out_valid(out_valid8), .out_ready(out_ready),
    .sig(sig8), .match(match8), .o_dbg_state(dbg8)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // Driver tasks: every task starts and ends 1 time unit after a rising edge.
  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_beat(input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1; aa = a; bb = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (dbg8 !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", dbg8); end
    n_cmp++; if (sig8 !== 16'h0000) begin n_fail++; $display("FAIL rst_sig: got %h want 0000", sig8); end
    n_cmp++; if ({in_ready1, in_ready2, in_ready8} !== 3'b000) begin n_fail++; $display("FAIL rst_in_ready: got %b want 000", {in_ready1, in_ready2, in_ready8}); end
    n_cmp++; if ({out_valid1, out_valid2, out_valid8, match1, match2, match8} !== 6'b0) begin n_fail++; $display("FAIL rst_valid_match: got %b want 000000", {out_valid1, out_valid2, out_valid8, match1, match2, match8}); end
    @(posedge clk); #1 rst_n = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (dbg2 !== 2'd0) begin n_fail++; $display("FAIL idle_no_start: got state %0d want 0", dbg2); end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_basic_match();
    do_reset();
    exp_sig = 16'h0003;
    pulse_start();
    n_cmp++; if (in_ready2 !== 1'b1 || sig2 !== 16'h0000) begin n_fail++; $display("FAIL basic_acc_entry: got ready %b sig %h want 1 0000", in_ready2, sig2); end
    drive_beat(16'h0001, 16'h0000);
    n_cmp++; if (sig2 !== 16'h0001 || out_valid2 !== 1'b0) begin n_fail++; $display("FAIL basic_beat1: got sig %h valid %b want 0001 0", sig2, out_valid2); end
    drive_beat(16'h0000, 16'h0100);
    n_cmp++; if (out_valid2 !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %b want 1", out_valid2); end
    n_cmp++; if (sig2 !== 16'h0003) begin n_fail++; $display("FAIL basic_sig: got %h want 0003", sig2); end
    n_cmp++; if (match2 !== 1'b1) begin n_fail++; $display("FAIL basic_match: got %b want 1", match2); end
    handshake();
    n_cmp++; if (out_valid2 !== 1'b0 || dbg2 !== 2'd0) begin n_fail++; $display("FAIL basic_to_idle: got valid %b state %0d want 0 0", out_valid2, dbg2); end
  endtask

  task automatic test_hold();
    do_reset();
    exp_sig = 16'h0004;
    pulse_start();
    drive_beat(16'h0001, 16'h0000);
    drive_beat(16'h0000, 16'h0100);
    n_cmp++; if (sig2 !== 16'h0003 || match2 !== 1'b0) begin n_fail++; $display("FAIL hold_result: got sig %h match %b want 0003 0", sig2, match2); end
    exp_sig = 16'h0003;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid2 !== 1'b1 || sig2 !== 16'h0003 || match2 !== 1'b0) begin n_fail++; $display("FAIL hold_cycle%0d: got valid %b sig %h match %b want 1 0003 0", i, out_valid2, sig2, match2); end
    end
    in_valid = 1'b0;
    handshake();
    n_cmp++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL hold_release: got valid %b want 0", out_valid2); end
  endtask

  task automatic test_rotate_swap();
    do_reset();
    exp_sig = 16'h1235;
    pulse_start();
    drive_beat(16'h8000, 16'h0000);
    drive_beat(16'h0000, 16'h3412);
    n_cmp++; if (sig2 !== 16'h1235 || match2 !== 1'b1) begin n_fail++; $display("FAIL rot_swap: got sig %h match %b want 1235 1", sig2, match2); end
  endtask

  task automatic test_single_beat();
    do_reset();
    exp_sig = 16'hFFFF;
    pulse_start();
    drive_beat(16'h00FF, 16'h00FF);
    n_cmp++; if (dbg1 !== 2'd2 || out_valid1 !== 1'b1) begin n_fail++; $display("FAIL n1_done: got state %0d valid %b want 2 1", dbg1, out_valid1); end
    n_cmp++; if (sig1 !== 16'hFFFF || match1 !== 1'b1) begin n_fail++; $display("FAIL n1_sig: got sig %h match %b want ffff 1", sig1, match1); end
  endtask

  task automatic test_random_valid();
    int acc;
    acc = 0;
    do_reset();
    aa = 16'hFFFF; bb = 16'hFFFF; exp_sig = 16'h0000;
    pulse_start();
    for (int cyc = 0; cyc < 300; cyc++) begin
      in_valid = 1'($urandom_range(0, 1));
      if (in_valid && in_ready8) acc++;
      @(posedge clk); #1;
      if (out_valid8) break;
    end
    in_valid = 1'b0;
    n_cmp++; if (out_valid8 !== 1'b1) begin n_fail++; $display("FAIL rand_timeout: got valid %b want 1 within budget", out_valid8); end
    n_cmp++; if (acc !== 8) begin n_fail++; $display("FAIL rand_count: got %0d beats want 8", acc); end
    n_cmp++; if (sig8 !== 16'h0000 || match8 !== 1'b1) begin n_fail++; $display("FAIL rand_sig: got sig %h match %b want 0000 1", sig8, match8); end
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (in_ready8 !== 1'b0 || dbg8 !== 2'd2) begin n_fail++; $display("FAIL rand_extra%0d: got ready %b state %0d want 0 2", i, in_ready8, dbg8); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_start_ignored();
    do_reset();
    exp_sig = 16'h1235;
    pulse_start();
    drive_beat(16'h8000, 16'h0000);
    pulse_start();
    n_cmp++; if (dbg2 !== 2'd1 || sig2 !== 16'h8000) begin n_fail++; $display("FAIL start_in_acc: got state %0d sig %h want 1 8000", dbg2, sig2); end
    drive_beat(16'h0000, 16'h3412);
    n_cmp++; if (sig2 !== 16'h1235 || out_valid2 !== 1'b1) begin n_fail++; $display("FAIL start_acc_result: got sig %h valid %b want 1235 1", sig2, out_valid2); end
    pulse_start();
    n_cmp++; if (dbg2 !== 2'd2 || sig2 !== 16'h1235) begin n_fail++; $display("FAIL start_in_done: got state %0d sig %h want 2 1235", dbg2, sig2); end
    start = 1'b1;
    handshake();
    start = 1'b0;
    n_cmp++; if (dbg2 !== 2'd1 || in_ready2 !== 1'b1 || out_valid2 !== 1'b0) begin n_fail++; $display("FAIL start_with_hs_state: got state %0d ready %b valid %b want 1 1 0", dbg2, in_ready2, out_valid2); end
    n_cmp++; if (sig2 !== 16'h0000) begin n_fail++; $display("FAIL start_with_hs_sig: got %h want 0000", sig2); end
  endtask

  task automatic test_back_to_back_abort();
    do_reset();
    exp_sig = 16'h0016;
    pulse_start();
    drive_beat(16'hAAAA, 16'h1234);
    drive_beat(16'h5555, 16'hFFFF);
    drive_beat(16'h0F0F, 16'h00F0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (dbg8 !== 2'd0 || in_ready8 !== 1'b0 || out_valid8 !== 1'b0) begin n_fail++; $display("FAIL abort_ctrl: got state %0d ready %b valid %b want 0 0 0", dbg8, in_ready8, out_valid8); end
    n_cmp++; if (sig8 !== 16'h0000 || match8 !== 1'b0) begin n_fail++; $display("FAIL abort_data: got sig %h match %b want 0000 0", sig8, match8); end
    @(posedge clk); #1 rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    n_cmp++; if (in_ready8 !== 1'b0) begin n_fail++; $display("FAIL abort_needs_start: got ready %b want 0", in_ready8); end
    pulse_start();
    for (int k = 1; k <= 8; k++) begin
      drive_beat(16'(k), 16'h0000);
      if (k < 8) begin
        n_cmp++; if (out_valid8 !== 1'b0) begin n_fail++; $display("FAIL b2b_early_done%0d: got valid %b want 0", k, out_valid8); end
      end
    end
    n_cmp++; if (out_valid8 !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got valid %b want 1", out_valid8); end
    n_cmp++; if (sig8 !== 16'h0016 || match8 !== 1'b1) begin n_fail++; $display("FAIL b2b_sig: got sig %h match %b want 0016 1", sig8, match8); end
  endtask

  initial begin
    test_reset();
    test_basic_match();
    test_hold();
    test_rotate_swap();
    test_single_beat();
    test_random_valid();
    test_start_ignored();
    test_back_to_back_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
